// File: rtl/byte_to_word_rx_pkg.sv
// byte_to_word_rx_pkg: state encodings, mode constants and default timeout shared by the serial word links
package byte_to_word_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_COLLECT = 3'b001,
        S_WORD    = 3'b010,
        S_BYTE    = 3'b011,
        S_TIMEOUT = 3'b100
    } state_t;

    localparam logic MODE_BYTE = 1'b0;
    localparam logic MODE_WORD = 1'b1;

    // Three frames at 87 clocks/bit for the common baud rate.
    localparam int DEFAULT_TIMEOUT_CLKS = 2610;

endpackage

// File: rtl/rx_timeout_timer.sv
// rx_timeout_timer: clear/enable counter that flags expiry after LIMIT enabled cycles and saturates
module rx_timeout_timer
    import byte_to_word_rx_pkg::*;
#(
    parameter int LIMIT = DEFAULT_TIMEOUT_CLKS,
    parameter int W     = $clog2(LIMIT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [W-1:0] count;

    assign expire = enable && !clear && count == W'(LIMIT - 1);

    // Count enabled cycles, holding at the terminal value instead of wrapping.
    always_ff @(posedge clock)
        if (reset || clear)
            count <= '0;
        else if (enable && count != W'(LIMIT - 1))
            count <= count + 1'b1;

endmodule

// File: rtl/byte_to_word_rx.sv
// byte_to_word_rx: reassembles LSB-first 32-bit words from UART byte strobes, with byte bypass and inter-byte timeout
module byte_to_word_rx
    import byte_to_word_rx_pkg::*;
#(
    parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS,
    parameter int CNT_W        = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_mode_select,
    input  logic             i_rx_valid,
    input  logic [7:0]       i_rx_byte,
    output logic [31:0]      o_word,
    output logic             o_word_valid,
    output logic [7:0]       o_byte,
    output logic             o_byte_valid,
    output logic             o_timeout,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_word_count,
    output logic [2:0]       main_state
);

    state_t             state, state_d;
    logic [1:0]         idx, idx_d;
    logic [23:0]        asm_q, asm_d;
    logic [31:0]        word_d;
    logic [7:0]         byte_d;
    logic               word_valid_d, byte_valid_d, timeout_d;
    logic [CNT_W-1:0]   count_d;
    logic               expire;

    assign o_busy     = state == S_COLLECT;
    assign main_state = state;

    rx_timeout_timer #(.LIMIT(TIMEOUT_CLKS)) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (i_rx_valid),
        .enable (state == S_COLLECT),
        .expire (expire)
    );

    // Next-state and next-output logic; the one-cycle states behave like idle so back-to-back bytes are not lost.
    always_comb begin
        state_d      = S_IDLE;
        idx_d        = idx;
        asm_d        = asm_q;
        word_d       = o_word;
        byte_d       = o_byte;
        word_valid_d = 1'b0;
        byte_valid_d = 1'b0;
        timeout_d    = 1'b0;
        count_d      = o_word_count;
        case (state)
            S_IDLE, S_WORD, S_BYTE, S_TIMEOUT: begin
                if (i_rx_valid && i_mode_select == MODE_WORD) begin
                    state_d = S_COLLECT;
                    asm_d   = {16'h0, i_rx_byte};
                    idx_d   = 2'd1;
                end else if (i_rx_valid) begin
                    state_d      = S_BYTE;
                    byte_d       = i_rx_byte;
                    byte_valid_d = 1'b1;
                end
            end
            S_COLLECT: begin
                if (i_rx_valid && idx == 2'd3) begin
                    state_d      = S_WORD;
                    word_d       = {i_rx_byte, asm_q};
                    word_valid_d = 1'b1;
                    count_d      = &o_word_count ? o_word_count : o_word_count + 1'b1;
                    idx_d        = 2'd0;
                end else if (i_rx_valid) begin
                    state_d = S_COLLECT;
                    asm_d   = asm_q | (24'(i_rx_byte) << {idx, 3'b000});
                    idx_d   = idx + 1'b1;
                end else if (expire) begin
                    state_d   = S_TIMEOUT;
                    timeout_d = 1'b1;
                    idx_d     = 2'd0;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Register state, assembly data and all outputs.
    always_ff @(posedge clock)
        if (reset) begin
            state        <= S_IDLE;
            idx          <= 2'd0;
            asm_q        <= '0;
            o_word       <= '0;
            o_word_valid <= 1'b0;
            o_byte       <= '0;
            o_byte_valid <= 1'b0;
            o_timeout    <= 1'b0;
            o_word_count <= '0;
        end else begin
            state        <= state_d;
            idx          <= idx_d;
            asm_q        <= asm_d;
            o_word       <= word_d;
            o_word_valid <= word_valid_d;
            o_byte       <= byte_d;
            o_byte_valid <= byte_valid_d;
            o_timeout    <= timeout_d;
            o_word_count <= count_d;
        end

endmodule

// File: tb/tb_byte_to_word_rx.sv
// tb_byte_to_word_rx: directed and randomized byte streams checked every cycle against a queue-based model
module tb_byte_to_word_rx;

    localparam int T = 2610;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mode_sel = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;
    logic [31:0] o_word;
    logic        o_word_valid;
    logic [7:0]  o_byte;
    logic        o_byte_valid;
    logic        o_timeout;
    logic        o_busy;
    logic [15:0] o_word_count;
    logic [2:0]  main_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    byte_to_word_rx #(.TIMEOUT_CLKS(T), .CNT_W(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .i_mode_select(mode_sel),
        .i_rx_valid   (rx_valid),
        .i_rx_byte    (rx_byte),
        .o_word       (o_word),
        .o_word_valid (o_word_valid),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .o_timeout    (o_timeout),
        .o_busy       (o_busy),
        .o_word_count (o_word_count),
        .main_state   (main_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: pending bytes of the current word in a queue, silent-cycle count since the last accepted byte.
    logic [7:0]  q[$];
    int          silent = 0;
    logic [31:0] m_word = 0;
    logic [7:0]  m_byte = 0;
    logic [15:0] m_cnt = 0;
    logic        m_wv = 0, m_bv = 0, m_to = 0;

    always @(posedge clock) begin
        m_wv = 1'b0;
        m_bv = 1'b0;
        m_to = 1'b0;
        if (reset) begin
            q.delete();
            silent = 0;
            m_word = 0;
            m_byte = 0;
            m_cnt  = 0;
        end else if (q.size() == 0) begin
            if (rx_valid && mode_sel) begin
                q.push_back(rx_byte);
                silent = 0;
            end else if (rx_valid) begin
                m_byte = rx_byte;
                m_bv   = 1'b1;
            end
        end else if (rx_valid) begin
            q.push_back(rx_byte);
            silent = 0;
            if (q.size() == 4) begin
                m_word = 0;
                foreach (q[i]) m_word += 32'(q[i]) << (8 * i);
                m_wv = 1'b1;
                if (m_cnt != 16'hFFFF) m_cnt++;
                q.delete();
            end
        end else begin
            silent++;
            if (silent == T) begin
                m_to = 1'b1;
                q.delete();
            end
        end
    end

    // Compare every DUT output against the model mid-cycle.
    always @(negedge clock) begin
        logic [2:0] m_state;
        m_state = q.size() != 0 ? 3'd1 : m_wv ? 3'd2 : m_bv ? 3'd3 : m_to ? 3'd4 : 3'd0;
        check("word", o_word, m_word);
        check("word_valid", 32'(o_word_valid), 32'(m_wv));
        check("byte", 32'(o_byte), 32'(m_byte));
        check("byte_valid", 32'(o_byte_valid), 32'(m_bv));
        check("timeout", 32'(o_timeout), 32'(m_to));
        check("busy", 32'(o_busy), 32'(q.size() != 0));
        check("word_count", 32'(o_word_count), 32'(m_cnt));
        check("state", 32'(main_state), 32'(m_state));
    end

    task automatic send(input logic [7:0] b, input logic m);
        rx_valid = 1'b1;
        rx_byte  = b;
        mode_sel = m;
        @(negedge clock);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("reset_word", o_word, 32'h0);
        check("reset_state", 32'(main_state), 32'h0);
        check("reset_count", 32'(o_word_count), 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Word assembly with wide spacing.
        send(8'h78, 1'b1); idle(870);
        send(8'h56, 1'b1); idle(870);
        send(8'h34, 1'b1); idle(870);
        send(8'h12, 1'b1);
        check("t1_word", o_word, 32'h12345678);
        check("t1_valid", 32'(o_word_valid), 32'h1);
        check("t1_count", 32'(o_word_count), 32'h1);
        idle(1);
        check("t1_pulse_drop", 32'(o_word_valid), 32'h0);

        // Byte bypass.
        idle(5);
        send(8'hA5, 1'b0);
        check("t2_byte", 32'(o_byte), 32'hA5);
        check("t2_bvalid", 32'(o_byte_valid), 32'h1);
        check("t2_count", 32'(o_word_count), 32'h1);
        idle(3);

        // Timeout discards a partial word.
        send(8'h11, 1'b1);
        send(8'h22, 1'b1);
        idle(T - 1);
        check("t3_no_to_yet", 32'(o_timeout), 32'h0);
        idle(1);
        check("t3_timeout", 32'(o_timeout), 32'h1);
        check("t3_word_held", o_word, 32'h12345678);
        idle(2);
        send(8'hEF, 1'b1); send(8'hBE, 1'b1); send(8'hAD, 1'b1); send(8'hDE, 1'b1);
        check("t3_word", o_word, 32'hDEADBEEF);
        check("t3_count", 32'(o_word_count), 32'h2);
        idle(3);

        // Reset mid-word.
        send(8'hA1, 1'b1); send(8'hA2, 1'b1); send(8'hA3, 1'b1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t4_word_clr", o_word, 32'h0);
        check("t4_count_clr", 32'(o_word_count), 32'h0);
        check("t4_busy_clr", 32'(o_busy), 32'h0);
        send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h03, 1'b1); send(8'h04, 1'b1);
        check("t4_word", o_word, 32'h04030201);
        idle(2);

        // Mode change mid-word is ignored until the next frame.
        send(8'hC1, 1'b1); send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b0);
        check("t5_word", o_word, 32'hC4C3C2C1);
        check("t5_count", 32'(o_word_count), 32'h2);
        idle(1);
        send(8'h5A, 1'b0);
        check("t5_bypass", 32'(o_byte), 32'h5A);
        idle(2);

        // Strobe on the expiry cycle wins; strobe during S_WORD starts the next word.
        send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1);
        idle(T - 1);
        send(8'h44, 1'b1);
        check("t6_word", o_word, 32'h44332211);
        check("t6_no_to", 32'(o_timeout), 32'h0);
        send(8'h99, 1'b1);
        check("t6_busy", 32'(o_busy), 32'h1);
        send(8'hAA, 1'b1); send(8'hBB, 1'b1); send(8'hCC, 1'b1);
        check("t6_next_word", o_word, 32'hCCBBAA99);
        idle(2);

        // Randomized streams with back-to-back strobes, long gaps near the expiry point and occasional resets.
        for (int k = 0; k < 300; k++) begin
            int r;
            int gap;
            r = $urandom_range(0, 99);
            if (r < 3) begin
                reset = 1'b1;
                @(negedge clock);
                reset = 1'b0;
            end
            r = $urandom_range(0, 99);
            gap = r < 60 ? int'($urandom_range(0, 3)) :
                  r < 96 ? int'($urandom_range(4, 60)) : T - 2 + int'($urandom_range(0, 3));
            send(8'($urandom), $urandom_range(0, 99) < 80);
            idle(gap);
        end
        idle(T + 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
